// File: rtl/present_core_iter.sv
// Iterative PRESENT-style cipher engine. One round per clock, on-the-fly key schedule,
// runtime encrypt/decrypt and a one-entry cache of the fully expanded decryption key.
module present_core_iter #(
    parameter int unsigned BLOCK_W = 16,
    parameter int unsigned KEY_W   = 32,
    parameter int unsigned ROUNDS  = 7,
    parameter int unsigned KEY_ROT = 8,
    parameter int unsigned CTR_LSB = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               mode,
    input  logic [KEY_W-1:0]   key,
    input  logic [BLOCK_W-1:0] din,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] dout,
    output logic               busy
);

    localparam logic [4:0] LastCtr = 5'(ROUNDS);

    typedef enum logic [1:0] {StIdle, StKeyexp, StRound, StDone} state_e;

    state_e             st_q;
    logic [KEY_W-1:0]   key_q;
    logic [BLOCK_W-1:0] dat_q;
    logic [4:0]         ctr_q;
    logic               mode_q;
    logic               cache_valid_q;
    logic [KEY_W-1:0]   cache_key_q;
    // Whole key register after the last forward step, not just its round key.
    logic [KEY_W-1:0]   cache_final_q;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [63:0] t;
        t = 64'hC56B90AD3EF84712;
        return t[(15 - int'(x)) * 4 +: 4];
    endfunction

    function automatic logic [3:0] sbox_inv(input logic [3:0] x);
        logic [63:0] t;
        t = 64'h5EF8C12DB463079A;
        return t[(15 - int'(x)) * 4 +: 4];
    endfunction

    function automatic logic [BLOCK_W-1:0] s_layer(input logic [BLOCK_W-1:0] x);
        logic [BLOCK_W-1:0] r;
        for (int n = 0; n < int'(BLOCK_W / 4); n++) r[4*n +: 4] = sbox(x[4*n +: 4]);
        return r;
    endfunction

    function automatic logic [BLOCK_W-1:0] s_inv_layer(input logic [BLOCK_W-1:0] x);
        logic [BLOCK_W-1:0] r;
        for (int n = 0; n < int'(BLOCK_W / 4); n++) r[4*n +: 4] = sbox_inv(x[4*n +: 4]);
        return r;
    endfunction

    logic [BLOCK_W-1:0] rk;
    logic [BLOCK_W-1:0] sx;
    logic [BLOCK_W-1:0] p_out;
    logic [BLOCK_W-1:0] pinv_out;
    logic [BLOCK_W-1:0] enc_fin;
    logic [BLOCK_W-1:0] dec_next;
    logic [KEY_W-1:0]   kf_rot;
    logic [KEY_W-1:0]   kf;
    logic [KEY_W-1:0]   ki_x;
    logic [KEY_W-1:0]   ki;
    logic               hit;

    assign rk = key_q[KEY_W-1 -: BLOCK_W];
    assign sx = s_layer(dat_q ^ rk);

    // Bit permutation and its inverse as pure wiring; the top bit maps to itself.
    assign p_out[BLOCK_W-1]    = sx[BLOCK_W-1];
    assign pinv_out[BLOCK_W-1] = dat_q[BLOCK_W-1];
    for (genvar i = 0; i < int'(BLOCK_W - 1); i++) begin : g_perm
        localparam int unsigned Dst = (i * (BLOCK_W / 4)) % (BLOCK_W - 1);
        assign p_out[Dst]  = sx[i];
        assign pinv_out[i] = dat_q[Dst];
    end

    // Forward and inverse key-schedule steps, both keyed by the current counter.
    always_comb begin
        kf_rot = (key_q << KEY_ROT) | (key_q >> (KEY_W - KEY_ROT));
        kf = kf_rot;
        kf[KEY_W-1 -: 4] = sbox(kf_rot[KEY_W-1 -: 4]);
        kf[CTR_LSB +: 5] = kf_rot[CTR_LSB +: 5] ^ ctr_q;
        ki_x = key_q;
        ki_x[CTR_LSB +: 5] = key_q[CTR_LSB +: 5] ^ ctr_q;
        ki_x[KEY_W-1 -: 4] = sbox_inv(key_q[KEY_W-1 -: 4]);
        ki = (ki_x >> KEY_ROT) | (ki_x << (KEY_W - KEY_ROT));
    end

    assign enc_fin  = p_out ^ kf[KEY_W-1 -: BLOCK_W];
    assign dec_next = s_inv_layer(pinv_out) ^ ki[KEY_W-1 -: BLOCK_W];
    assign hit      = cache_valid_q && (key == cache_key_q);

    assign in_ready = (st_q == StIdle) && !reset;
    assign busy     = (st_q != StIdle);

    // Control FSM, round datapath registers, key cache and registered result.
    always_ff @(posedge clk) begin
        if (reset) begin
            st_q          <= StIdle;
            key_q         <= '0;
            dat_q         <= '0;
            ctr_q         <= '0;
            mode_q        <= 1'b0;
            cache_valid_q <= 1'b0;
            cache_key_q   <= '0;
            cache_final_q <= '0;
            out_valid     <= 1'b0;
            dout          <= '0;
        end else begin
            unique case (st_q)
                StIdle: begin
                    if (in_valid) begin
                        mode_q <= mode;
                        if (mode && hit) begin
                            key_q <= cache_final_q;
                            dat_q <= din ^ cache_final_q[KEY_W-1 -: BLOCK_W];
                            ctr_q <= LastCtr;
                            st_q  <= StRound;
                        end else begin
                            // Cache entry is rewritten once the final key is known.
                            key_q         <= key;
                            dat_q         <= din;
                            ctr_q         <= 5'd1;
                            cache_key_q   <= key;
                            cache_valid_q <= 1'b0;
                            st_q          <= mode ? StKeyexp : StRound;
                        end
                    end
                end
                StKeyexp: begin
                    key_q <= kf;
                    if (ctr_q == LastCtr) begin
                        dat_q         <= dat_q ^ kf[KEY_W-1 -: BLOCK_W];
                        cache_final_q <= kf;
                        cache_valid_q <= 1'b1;
                        ctr_q         <= LastCtr;
                        st_q          <= StRound;
                    end else begin
                        ctr_q <= ctr_q + 5'd1;
                    end
                end
                StRound: begin
                    if (!mode_q) begin
                        dat_q <= p_out;
                        key_q <= kf;
                        if (ctr_q == LastCtr) begin
                            dout          <= enc_fin;
                            out_valid     <= 1'b1;
                            cache_final_q <= kf;
                            cache_valid_q <= 1'b1;
                            st_q          <= StDone;
                        end else begin
                            ctr_q <= ctr_q + 5'd1;
                        end
                    end else begin
                        dat_q <= dec_next;
                        key_q <= ki;
                        if (ctr_q == 5'd1) begin
                            dout      <= dec_next;
                            out_valid <= 1'b1;
                            st_q      <= StDone;
                        end else begin
                            ctr_q <= ctr_q - 5'd1;
                        end
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        st_q      <= StIdle;
                    end
                end
                default: st_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_present_core_iter.sv
// Bench for present_core_iter: three configurations (default, one round, 64/80-bit) with a
// queue scoreboard fed from a bit-level reference model.
module tb_present_core_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        mode_b = 1'b0;
    logic        out_ready_b = 1'b0;
    logic [79:0] key_b = '0;
    logic [63:0] din_b = '0;
    logic [2:0]  iv = '0;
    logic [2:0]  rdy, ov, bsy;
    logic [15:0] dout0, dout1;
    logic [63:0] dout2;
    logic [63:0] dout_m [3];

    int total = 0;
    int bad = 0;
    logic [63:0] exp_q [$];

    int bw_c  [3] = '{16, 16, 64};
    int kw_c  [3] = '{32, 32, 80};
    int r_c   [3] = '{7, 1, 31};
    int rot_c [3] = '{8, 8, 61};
    int cl_c  [3] = '{11, 11, 15};

    present_core_iter u_dut_def (
        .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(rdy[0]), .mode(mode_b),
        .key(key_b[31:0]), .din(din_b[15:0]), .out_valid(ov[0]), .out_ready(out_ready_b),
        .dout(dout0), .busy(bsy[0])
    );

    present_core_iter #(.ROUNDS(1)) u_dut_r1 (
        .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(rdy[1]), .mode(mode_b),
        .key(key_b[31:0]), .din(din_b[15:0]), .out_valid(ov[1]), .out_ready(out_ready_b),
        .dout(dout1), .busy(bsy[1])
    );

    present_core_iter #(
        .BLOCK_W(64), .KEY_W(80), .ROUNDS(31), .KEY_ROT(61), .CTR_LSB(15)
    ) u_dut_big (
        .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(rdy[2]), .mode(mode_b),
        .key(key_b), .din(din_b), .out_valid(ov[2]), .out_ready(out_ready_b),
        .dout(dout2), .busy(bsy[2])
    );

    always_comb begin
        dout_m[0] = {48'h0, dout0};
        dout_m[1] = {48'h0, dout1};
        dout_m[2] = dout2;
    end

    // ---------------- reference model ----------------
    function automatic logic [3:0] m_s4(input logic [3:0] x);
        case (x)
            4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
            4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
            4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
            4'hC: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;  default: return 4'h2;
        endcase
    endfunction

    function automatic logic [79:0] m_fwd(input int sel, input logic [79:0] k, input int c);
        logic [79:0] one80, mk, k2;
        int kw, rot;
        kw = kw_c[sel];
        rot = rot_c[sel];
        one80 = 80'd1;
        mk = (one80 << kw) - one80;
        k2 = ((k << rot) | (k >> (kw - rot))) & mk;
        k2[kw-1 -: 4] = m_s4(k2[kw-1 -: 4]);
        k2 = k2 ^ (80'(c) << cl_c[sel]);
        return k2;
    endfunction

    function automatic logic [63:0] m_enc(input int sel, input logic [79:0] k,
                                          input logic [63:0] d);
        logic [79:0] one80, kk;
        logic [63:0] one64, mb, s, t, u;
        int bw, kw;
        bw = bw_c[sel];
        kw = kw_c[sel];
        one80 = 80'd1;
        one64 = 64'd1;
        kk = k & ((one80 << kw) - one80);
        mb = (bw == 64) ? '1 : ((one64 << bw) - one64);
        s = d & mb;
        for (int i = 1; i <= r_c[sel]; i++) begin
            s = s ^ 64'(kk >> (kw - bw));
            t = '0;
            for (int n = 0; n < bw / 4; n++) t[4*n +: 4] = m_s4(s[4*n +: 4]);
            u = '0;
            for (int j = 0; j < bw - 1; j++) u[(j * (bw / 4)) % (bw - 1)] = t[j];
            u[bw-1] = t[bw-1];
            s = u;
            kk = m_fwd(sel, kk, i);
        end
        return s ^ 64'(kk >> (kw - bw));
    endfunction

    // ---------------- stimulus / collection ----------------
    task automatic drive_req(input int sel, input logic m, input logic [79:0] k,
                             input logic [63:0] d, input logic [63:0] e, output bit ok);
        int n;
        n = 0;
        while (!rdy[sel] && n < 50) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        ok = rdy[sel];
        exp_q.push_back(e);
        mode_b = m;
        key_b = k;
        din_b = d;
        iv[sel] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv[sel] = 1'b0;
        // Scramble the request inputs: the engine must already have captured them.
        mode_b = ~m;
        key_b = 80'({$urandom, $urandom, $urandom});
        din_b = {$urandom, $urandom};
    endtask

    task automatic wait_out(input int sel, output int lat, output bit got);
        lat = 1;
        while (!ov[sel] && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        got = ov[sel];
    endtask

    task automatic retire();
        out_ready_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready_b = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            total++;
            if (rdy[s] !== 1'b0 || ov[s] !== 1'b0 || bsy[s] !== 1'b0 || dout_m[s] !== 64'h0) begin
                bad++;
                $display("FAIL reset_state[%0d]: rdy=%b ov=%b busy=%b dout=%h, want 0 0 0 0",
                         s, rdy[s], ov[s], bsy[s], dout_m[s]);
            end
        end
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (rdy !== 3'b111) begin
            bad++;
            $display("FAIL reset_release: in_ready=%b want 111", rdy);
        end
    endtask

    task automatic test_round1();
        bit ok, got;
        int lat;
        logic [63:0] e;
        drive_req(1, 1'b0, 80'h0, 64'h0, 64'h3F00, ok);
        wait_out(1, lat, got);
        e = exp_q.pop_front();
        total++;
        if (!ok || !got || dout_m[1] !== e) begin
            bad++;
            $display("FAIL r1_enc: dout=%h want %h (ok=%0d got=%0d)", dout_m[1], e, ok, got);
        end
        total++;
        if (lat !== 2) begin
            bad++;
            $display("FAIL r1_latency: %0d want 2", lat);
        end
        retire();
    endtask

    task automatic test_enc_hit();
        bit ok, got;
        int lat;
        logic [63:0] e, c;
        c = m_enc(0, 80'hDEADBEEF, 64'h1234);
        drive_req(0, 1'b0, 80'hDEADBEEF, 64'h1234, c, ok);
        wait_out(0, lat, got);
        e = exp_q.pop_front();
        total++;
        if (!ok || !got || dout_m[0] !== e || lat !== 8) begin
            bad++;
            $display("FAIL enc: dout=%h lat=%0d want %h lat=8", dout_m[0], lat, e);
        end
        retire();
        drive_req(0, 1'b1, 80'hDEADBEEF, c, 64'h1234, ok);
        wait_out(0, lat, got);
        e = exp_q.pop_front();
        total++;
        if (!ok || !got || dout_m[0] !== e) begin
            bad++;
            $display("FAIL dec_hit: dout=%h want %h", dout_m[0], e);
        end
        total++;
        if (lat !== 8) begin
            bad++;
            $display("FAIL dec_hit_latency: %0d want 8", lat);
        end
        retire();
    endtask

    task automatic test_dec_miss();
        bit ok, got;
        int lat;
        logic [63:0] e, c;
        c = m_enc(0, 80'hDEADBEEF, 64'h1234);
        apply_reset();
        for (int pass = 0; pass < 2; pass++) begin
            drive_req(0, 1'b1, 80'hDEADBEEF, c, 64'h1234, ok);
            wait_out(0, lat, got);
            e = exp_q.pop_front();
            total++;
            if (!ok || !got || dout_m[0] !== e) begin
                bad++;
                $display("FAIL dec_miss[%0d]: dout=%h want %h", pass, dout_m[0], e);
            end
            total++;
            if (lat !== ((pass == 0) ? 15 : 8)) begin
                bad++;
                $display("FAIL dec_miss_latency[%0d]: %0d want %0d", pass, lat,
                         (pass == 0) ? 15 : 8);
            end
            retire();
        end
    endtask

    task automatic test_backpressure();
        bit ok, got;
        int lat;
        logic [63:0] e, e2;
        logic [79:0] k;
        k = 80'h0000_0000_0000_A5C3_1E77;
        drive_req(0, 1'b0, k, 64'hBEEF, m_enc(0, k, 64'hBEEF), ok);
        wait_out(0, lat, got);
        e = exp_q.pop_front();
        total++;
        if (!ok || !got || dout_m[0] !== e) begin
            bad++;
            $display("FAIL hold_first: dout=%h want %h", dout_m[0], e);
        end
        for (int j = 0; j < 20; j++) begin
            iv[0] = j[0];
            mode_b = 1'b1;
            din_b = {$urandom, $urandom};
            total++;
            if (ov[0] !== 1'b1 || rdy[0] !== 1'b0 || dout_m[0] !== e) begin
                bad++;
                $display("FAIL hold[%0d]: ov=%b rdy=%b dout=%h want 1 0 %h",
                         j, ov[0], rdy[0], dout_m[0], e);
            end
            @(posedge clk);
            @(negedge clk);
        end
        // Retire and present a new request in the same cycle.
        e2 = m_enc(0, k, 64'h0F1E);
        exp_q.push_back(e2);
        mode_b = 1'b0;
        key_b = k;
        din_b = 64'h0F1E;
        iv[0] = 1'b1;
        out_ready_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready_b = 1'b0;
        total++;
        if (rdy[0] !== 1'b1 || ov[0] !== 1'b0 || bsy[0] !== 1'b0) begin
            bad++;
            $display("FAIL release: rdy=%b ov=%b busy=%b want 1 0 0", rdy[0], ov[0], bsy[0]);
        end
        @(posedge clk);
        @(negedge clk);
        iv[0] = 1'b0;
        total++;
        if (bsy[0] !== 1'b1) begin
            bad++;
            $display("FAIL b2b_accept: busy=%b want 1", bsy[0]);
        end
        wait_out(0, lat, got);
        e = exp_q.pop_front();
        total++;
        if (!got || dout_m[0] !== e || lat !== 8) begin
            bad++;
            $display("FAIL b2b_result: dout=%h lat=%0d want %h lat=8", dout_m[0], lat, e);
        end
        retire();
    endtask

    task automatic test_reset_abort();
        bit ok, got;
        int lat;
        logic [63:0] e, c;
        logic [79:0] k;
        k = 80'h0000_0000_0000_1357_9BDF;
        c = m_enc(0, k, 64'h4C2A);
        drive_req(0, 1'b0, k, 64'h4C2A, c, ok);
        wait_out(0, lat, got);
        e = exp_q.pop_front();
        total++;
        if (!ok || !got || dout_m[0] !== e) begin
            bad++;
            $display("FAIL abort_setup: dout=%h want %h", dout_m[0], e);
        end
        retire();
        drive_req(0, 1'b0, k, 64'h4C2A, c, ok);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (ov[0] !== 1'b0 || bsy[0] !== 1'b0) begin
            bad++;
            $display("FAIL abort_state: ov=%b busy=%b want 0 0", ov[0], bsy[0]);
        end
        reset = 1'b0;
        exp_q.delete();
        drive_req(0, 1'b1, k, c, 64'h4C2A, ok);
        wait_out(0, lat, got);
        e = exp_q.pop_front();
        total++;
        if (!ok || !got || dout_m[0] !== e || lat !== 15) begin
            bad++;
            $display("FAIL abort_dec: dout=%h lat=%0d want %h lat=15", dout_m[0], lat, e);
        end
        retire();
    endtask

    task automatic test_sweep();
        bit ok, got;
        int lat;
        logic [63:0] e, c, d;
        logic [79:0] k;
        for (int v = 0; v < 1000; v++) begin
            k = 80'({$urandom, $urandom, $urandom});
            d = {$urandom, $urandom};
            c = m_enc(2, k, d);
            drive_req(2, 1'b0, k, d, c, ok);
            wait_out(2, lat, got);
            e = exp_q.pop_front();
            total++;
            if (!ok || !got || dout_m[2] !== e || lat !== 32) begin
                bad++;
                $display("FAIL sweep_enc[%0d]: dout=%h lat=%0d want %h lat=32",
                         v, dout_m[2], lat, e);
            end
            retire();
            drive_req(2, 1'b1, k, c, d, ok);
            wait_out(2, lat, got);
            e = exp_q.pop_front();
            total++;
            if (!ok || !got || dout_m[2] !== e || lat !== 32) begin
                bad++;
                $display("FAIL sweep_dec[%0d]: dout=%h lat=%0d want %h lat=32",
                         v, dout_m[2], lat, e);
            end
            retire();
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_round1();
        test_enc_hit();
        test_dec_miss();
        test_backpressure();
        test_reset_abort();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
